serial_link_bridge: RTL and testbench

Parametrised serial front end between the pad ring (pad_in / pad_out_buffered on C, SI, SO) and the CPU core. Deserialises framed words arriving on SI into a WIDTH-bit valid/ready stream toward the core. Serialises core output words, buffered in a DEPTH-entry FIFO, onto SO. This replaces the fixed single-bit SI/SO wiring of the previous top level, and adds framing, error detection and flow control.

---
 rtl/serial_link_bridge.sv | 198 +++++++++++++++++++
 tb/tb_serial_link_bridge.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_link_bridge.sv
// serial_link_bridge: serial front end between the pad ring and the CPU core.
//   RX: deserialises frames on SI (start 0, WIDTH data bits MSB first, stop 1)
//       into a single-entry valid/ready holding register toward the core.
//   TX: buffers core words in a DEPTH-entry FIFO and serialises them onto SO
//       in the same frame format, back to back when the FIFO stays non-empty.
// Ports:
//   C, R            clock (rising edge), asynchronous active-high reset
//   SI, SO          serial in / out, both idle high
//   rx_data/valid/ready   received word stream toward the core
//   rx_frame_err    one-cycle pulse, stop bit sampled 0
//   rx_overrun      one-cycle pulse, completed word dropped (holding reg full)
//   tx_data/valid/ready   word stream from the core into the FIFO
//   tx_level        FIFO occupancy 0..DEPTH
module serial_link_bridge #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic             C,
  input  logic             R,
  input  logic             SI,
  output logic             SO,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic             rx_frame_err,
  output logic             rx_overrun,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [AW:0]      tx_level
);

  localparam int unsigned CW    = $clog2(WIDTH);
  localparam int unsigned WLast = WIDTH - 1;
  localparam logic [CW-1:0] BitLast   = WLast[CW-1:0];
  localparam logic [AW:0]   LevelFull = DEPTH[AW:0];

  typedef enum logic [1:0] {RxIdle, RxData, RxStop, RxBreak} rx_state_e;
  typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;

  // ---------------------------------------------------------------- RX path
  rx_state_e        rx_state_q, rx_state_d;
  logic [CW-1:0]    rx_cnt_q, rx_cnt_d;
  logic [WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic [WIDTH-1:0] rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q, overrun_d;
  logic             word_done, rx_load;

  always_comb begin
    rx_state_d  = rx_state_q;
    rx_cnt_d    = rx_cnt_q;
    rx_shift_d  = rx_shift_q;
    word_done   = 1'b0;
    frame_err_d = 1'b0;
    unique case (rx_state_q)
      RxIdle: begin
        if (!SI) begin
          rx_state_d = RxData;
          rx_cnt_d   = '0;
        end
      end
      RxData: begin
        rx_shift_d = {rx_shift_q[WIDTH-2:0], SI};
        rx_cnt_d   = rx_cnt_q + 1'b1;
        if (rx_cnt_q == BitLast) rx_state_d = RxStop;
      end
      RxStop: begin
        if (SI) begin
          word_done  = 1'b1;
          rx_state_d = RxIdle;
        end else begin
          frame_err_d = 1'b1;
          rx_state_d  = RxBreak;
        end
      end
      RxBreak: begin
        // Line held low: wait for it to return high before hunting a start bit.
        if (SI) rx_state_d = RxIdle;
      end
      default: rx_state_d = RxIdle;
    endcase

    // A completed word may replace a word being consumed this same cycle.
    rx_load    = word_done && (!rx_valid_q || rx_ready);
    overrun_d  = word_done && !rx_load;
    rx_data_d  = rx_load ? rx_shift_q : rx_data_q;
    rx_valid_d = rx_valid_q;
    if (rx_load) begin
      rx_valid_d = 1'b1;
    end else if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end
  end

  always_ff @(posedge C or posedge R) begin
    if (R) begin
      rx_state_q  <= RxIdle;
      rx_cnt_q    <= '0;
      rx_shift_q  <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_shift_q  <= rx_shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign rx_data      = rx_data_q;
  assign rx_valid     = rx_valid_q;
  assign rx_frame_err = frame_err_q;
  assign rx_overrun   = overrun_q;

  // ---------------------------------------------------------------- TX path
  logic [WIDTH-1:0] fifo_mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  tx_state_e        tx_state_q, tx_state_d;
  logic [CW-1:0]    tx_cnt_q, tx_cnt_d;
  logic [WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic             push, pop;

  assign tx_ready = (level_q != LevelFull);
  assign tx_level = level_q;
  assign push     = tx_valid && tx_ready;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_shift_d = tx_shift_q;
    pop        = 1'b0;
    SO         = 1'b1;
    unique case (tx_state_q)
      TxIdle, TxStop: begin
        // STOP drives the stop bit and chains straight into the next start bit.
        if (level_q != '0) begin
          pop        = 1'b1;
          tx_shift_d = fifo_mem[rd_ptr_q];
          tx_state_d = TxStart;
        end else begin
          tx_state_d = TxIdle;
        end
      end
      TxStart: begin
        SO         = 1'b0;
        tx_cnt_d   = '0;
        tx_state_d = TxData;
      end
      TxData: begin
        SO         = tx_shift_q[WIDTH-1];
        tx_shift_d = {tx_shift_q[WIDTH-2:0], 1'b0};
        tx_cnt_d   = tx_cnt_q + 1'b1;
        if (tx_cnt_q == BitLast) tx_state_d = TxStop;
      end
      default: tx_state_d = TxIdle;
    endcase

    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge C) begin
    if (push) fifo_mem[wr_ptr_q] <= tx_data;
  end

  always_ff @(posedge C or posedge R) begin
    if (R) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      tx_state_q <= TxIdle;
      tx_cnt_q   <= '0;
      tx_shift_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_shift_q <= tx_shift_d;
    end
  end

endmodule

// File: tb/tb_serial_link_bridge.sv
// Self-checking bench for serial_link_bridge: directed RX/TX scenarios on a
// WIDTH=16/DEPTH=4 instance and random loopback on it and on a WIDTH=8/DEPTH=8
// instance. Expected words come from queues of what was sent; SO is decoded by
// a frame-level decoder in the bench.
module tb_serial_link_bridge;

  logic        C = 1'b0;
  logic        R = 1'b1;
  logic        si_drv, loop1;
  logic        si1, so1;
  logic [15:0] rx_data1, tx_data1;
  logic        rx_valid1, rx_ready1, fe1, ov1, tx_valid1, tx_ready1;
  logic [2:0]  tx_level1;

  logic        so2;
  logic [7:0]  rx_data2, tx_data2;
  logic        rx_valid2, rx_ready2, fe2, ov2, tx_valid2, tx_ready2;
  logic [3:0]  tx_level2;

  assign si1 = loop1 ? so1 : si_drv;

  serial_link_bridge #(.WIDTH(16), .DEPTH(4)) dut1 (
    .C(C), .R(R), .SI(si1), .SO(so1),
    .rx_data(rx_data1), .rx_valid(rx_valid1), .rx_ready(rx_ready1),
    .rx_frame_err(fe1), .rx_overrun(ov1),
    .tx_data(tx_data1), .tx_valid(tx_valid1), .tx_ready(tx_ready1), .tx_level(tx_level1)
  );

  serial_link_bridge #(.WIDTH(8), .DEPTH(8)) dut2 (
    .C(C), .R(R), .SI(so2), .SO(so2),
    .rx_data(rx_data2), .rx_valid(rx_valid2), .rx_ready(rx_ready2),
    .rx_frame_err(fe2), .rx_overrun(ov2),
    .tx_data(tx_data2), .tx_valid(tx_valid2), .tx_ready(tx_ready2), .tx_level(tx_level2)
  );

  always #5 C = ~C;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int fe_cnt1 = 0, ov_cnt1 = 0, fe_cnt2 = 0, ov_cnt2 = 0;
  int stop_bad1 = 0;
  logic [15:0] rx_q1[$], tx_exp1[$], dec_q1[$];
  logic [7:0]  rx_q2[$], tx_exp2[$];
  int          start_q1[$];

  // Frame-level decoder for SO of dut1 plus pulse and handshake monitors.
  logic        dec_act = 1'b0;
  int          dec_n   = 0;
  logic [15:0] dec_sh  = '0;

  always @(negedge C) begin
    cyc++;
    if (fe1 === 1'b1) fe_cnt1++;
    if (ov1 === 1'b1) ov_cnt1++;
    if (fe2 === 1'b1) fe_cnt2++;
    if (ov2 === 1'b1) ov_cnt2++;
    if (rx_valid1 === 1'b1 && rx_ready1 === 1'b1) rx_q1.push_back(rx_data1);
    if (rx_valid2 === 1'b1 && rx_ready2 === 1'b1) rx_q2.push_back(rx_data2);
    if (R) begin
      dec_act = 1'b0;
    end else if (!dec_act) begin
      if (so1 === 1'b0) begin
        dec_act = 1'b1;
        dec_n   = 0;
        start_q1.push_back(cyc);
      end
    end else if (dec_n < 16) begin
      dec_sh = {dec_sh[14:0], so1};
      dec_n++;
    end else begin
      if (so1 !== 1'b1) stop_bad1++;
      dec_q1.push_back(dec_sh);
      dec_act = 1'b0;
    end
  end

  task automatic step();
    @(posedge C);
    #1;
  endtask

  task automatic send_frame1(input logic [15:0] w, input logic stop_bit);
    si_drv = 1'b0;
    step();
    for (int i = 15; i >= 0; i--) begin
      si_drv = w[i];
      step();
    end
    si_drv = stop_bit;
    step();
    si_drv = 1'b1;
  endtask

  task automatic push_word1(input logic [15:0] w);
    int n = 0;
    tx_valid1 = 1'b1;
    tx_data1  = w;
    while (tx_ready1 !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    total++;
    if (n >= 200) begin
      bad++;
      $display("FAIL push1_timeout: waited %0d cycles, required < 200", n);
    end
    step();
    tx_exp1.push_back(w);
  endtask

  task automatic push_word2(input logic [7:0] w);
    int n = 0;
    tx_valid2 = 1'b1;
    tx_data2  = w;
    while (tx_ready2 !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    total++;
    if (n >= 200) begin
      bad++;
      $display("FAIL push2_timeout: waited %0d cycles, required < 200", n);
    end
    step();
    tx_exp2.push_back(w);
  endtask

  task automatic test_reset();
    R = 1'b1;
    si_drv = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      total += 4;
      if (so1 !== 1'b1) begin bad++; $display("FAIL reset_so: got %b want 1", so1); end
      if (rx_valid1 !== 1'b0) begin
        bad++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid1);
      end
      if (tx_level1 !== 3'd0) begin
        bad++; $display("FAIL reset_tx_level: got %0d want 0", tx_level1);
      end
      if (tx_ready1 !== 1'b1) begin
        bad++; $display("FAIL reset_tx_ready: got %b want 1", tx_ready1);
      end
    end
    R = 1'b0;
    step();
    total += 2;
    if (rx_data1 !== 16'h0) begin bad++; $display("FAIL reset_rx_data: got %h want 0", rx_data1); end
    if (fe1 !== 1'b0 || ov1 !== 1'b0) begin
      bad++; $display("FAIL reset_pulses: got fe=%b ov=%b want 0 0", fe1, ov1);
    end
  endtask

  task automatic test_rx_single();
    rx_ready1 = 1'b0;
    send_frame1(16'hA5C3, 1'b1);
    total += 2;
    if (rx_valid1 !== 1'b1) begin bad++; $display("FAIL rx1_valid: got %b want 1", rx_valid1); end
    if (rx_data1 !== 16'hA5C3) begin
      bad++; $display("FAIL rx1_data: got %h want a5c3", rx_data1);
    end
    repeat (5) step();
    total++;
    if (rx_valid1 !== 1'b1 || rx_data1 !== 16'hA5C3) begin
      bad++; $display("FAIL rx1_hold: got v=%b d=%h want 1 a5c3", rx_valid1, rx_data1);
    end
    rx_ready1 = 1'b1;
    step();
    rx_ready1 = 1'b0;
    total++;
    if (rx_valid1 !== 1'b0) begin bad++; $display("FAIL rx1_consume: got %b want 0", rx_valid1); end
  endtask

  task automatic test_rx_errors();
    int fe0 = fe_cnt1;
    int ov0 = ov_cnt1;
    send_frame1(16'h5A5A, 1'b0);
    si_drv = 1'b0;
    repeat (40) step();
    si_drv = 1'b1;
    repeat (2) step();
    total += 3;
    if (fe_cnt1 - fe0 !== 1) begin
      bad++; $display("FAIL frame_err_pulses: got %0d want 1", fe_cnt1 - fe0);
    end
    if (rx_valid1 !== 1'b0) begin bad++; $display("FAIL frame_err_valid: got %b want 0", rx_valid1); end
    if (ov_cnt1 - ov0 !== 0) begin
      bad++; $display("FAIL frame_err_overrun: got %0d want 0", ov_cnt1 - ov0);
    end
  endtask

  task automatic test_overrun();
    int ov0 = ov_cnt1;
    int fe0 = fe_cnt1;
    rx_ready1 = 1'b0;
    send_frame1(16'h1111, 1'b1);
    send_frame1(16'h2222, 1'b1);
    step();
    total += 4;
    if (rx_data1 !== 16'h1111) begin bad++; $display("FAIL ovr_data: got %h want 1111", rx_data1); end
    if (rx_valid1 !== 1'b1) begin bad++; $display("FAIL ovr_valid: got %b want 1", rx_valid1); end
    if (ov_cnt1 - ov0 !== 1) begin bad++; $display("FAIL ovr_pulses: got %0d want 1", ov_cnt1 - ov0); end
    if (fe_cnt1 - fe0 !== 0) begin bad++; $display("FAIL ovr_fe: got %0d want 0", fe_cnt1 - fe0); end
    rx_ready1 = 1'b1;
    step();
    rx_ready1 = 1'b0;
    total++;
    if (rx_valid1 !== 1'b0) begin bad++; $display("FAIL ovr_drain: got %b want 0", rx_valid1); end
  endtask

  task automatic test_tx_burst();
    logic [15:0] words [5];
    logic [2:0]  lvl_exp [5];
    logic        so_exp [5];
    words[0] = 16'h0001; words[1] = 16'h8000; words[2] = 16'hFFFF; words[3] = 16'h1234;
    words[4] = 16'($urandom_range(0, 65535));
    // Level after each push edge: the first word is popped one cycle after it lands.
    lvl_exp[0] = 3'd1; lvl_exp[1] = 3'd1; lvl_exp[2] = 3'd2; lvl_exp[3] = 3'd3; lvl_exp[4] = 3'd4;
    so_exp[0] = 1'b1; so_exp[1] = 1'b0; so_exp[2] = 1'b0; so_exp[3] = 1'b0; so_exp[4] = 1'b0;
    tx_exp1.delete(); dec_q1.delete(); start_q1.delete();
    for (int i = 0; i < 5; i++) begin
      tx_valid1 = 1'b1;
      tx_data1  = words[i];
      step();
      tx_exp1.push_back(words[i]);
      total += 2;
      if (tx_level1 !== lvl_exp[i]) begin
        bad++; $display("FAIL burst_level%0d: got %0d want %0d", i, tx_level1, lvl_exp[i]);
      end
      // cycle 1 is the start bit, cycles 2..4 are leading data bits of 0x0001
      if (so1 !== so_exp[i]) begin
        bad++; $display("FAIL burst_so%0d: got %b want %b", i, so1, so_exp[i]);
      end
    end
    total++;
    if (tx_ready1 !== 1'b0) begin bad++; $display("FAIL burst_full_ready: got %b want 0", tx_ready1); end
  endtask

  task automatic test_fifo_boundary();
    int n = 0;
    logic [15:0] w;
    w = 16'($urandom_range(0, 65535));
    tx_valid1 = 1'b1;
    tx_data1  = w;
    while (tx_ready1 !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    total += 2;
    if (n >= 100) begin bad++; $display("FAIL bnd_ready_rise: waited %0d want < 100", n); end
    if (tx_level1 !== 3'd3) begin bad++; $display("FAIL bnd_level_pre: got %0d want 3", tx_level1); end
    step();
    tx_exp1.push_back(w);
    total += 2;
    if (tx_level1 !== 3'd4) begin bad++; $display("FAIL bnd_level_post: got %0d want 4", tx_level1); end
    if (tx_ready1 !== 1'b0) begin bad++; $display("FAIL bnd_ready_post: got %b want 0", tx_ready1); end
    for (int i = 0; i < 10; i++) push_word1(16'($urandom_range(0, 65535)));
    tx_valid1 = 1'b0;
    n = 0;
    while (!(tx_level1 === 3'd0 && dec_q1.size() == tx_exp1.size() && !dec_act) && n < 1000) begin
      step();
      n++;
    end
    total += 3;
    if (n >= 1000) begin bad++; $display("FAIL tx_drain: waited %0d want < 1000", n); end
    if (dec_q1.size() != tx_exp1.size()) begin
      bad++; $display("FAIL tx_count: got %0d want %0d", dec_q1.size(), tx_exp1.size());
    end
    if (stop_bad1 !== 0) begin bad++; $display("FAIL tx_stop_bits: got %0d bad want 0", stop_bad1); end
    for (int i = 0; i < tx_exp1.size() && i < dec_q1.size(); i++) begin
      total++;
      if (dec_q1[i] !== tx_exp1[i]) begin
        bad++; $display("FAIL tx_word%0d: got %h want %h", i, dec_q1[i], tx_exp1[i]);
      end
    end
    for (int i = 1; i < start_q1.size(); i++) begin
      total++;
      if (start_q1[i] - start_q1[i-1] != 18) begin
        bad++; $display("FAIL tx_gap%0d: got %0d want 18", i, start_q1[i] - start_q1[i-1]);
      end
    end
  endtask

  task automatic test_reset_mid_tx();
    int fe0 = fe_cnt1;
    int ov0 = ov_cnt1;
    tx_valid1 = 1'b1;
    tx_data1  = 16'h0000;
    step();
    tx_valid1 = 1'b0;
    repeat (5) step();
    total++;
    if (so1 !== 1'b0) begin bad++; $display("FAIL mid_so_before: got %b want 0", so1); end
    #2;
    R = 1'b1;
    #1;
    total += 2;
    if (so1 !== 1'b1) begin bad++; $display("FAIL mid_so_async: got %b want 1", so1); end
    if (tx_level1 !== 3'd0) begin bad++; $display("FAIL mid_level: got %0d want 0", tx_level1); end
    step();
    R = 1'b0;
    repeat (25) step();
    total += 3;
    if (so1 !== 1'b1) begin bad++; $display("FAIL mid_so_after: got %b want 1", so1); end
    if (fe_cnt1 - fe0 !== 0 || ov_cnt1 - ov0 !== 0) begin
      bad++; $display("FAIL mid_pulses: got fe=%0d ov=%0d want 0 0", fe_cnt1 - fe0, ov_cnt1 - ov0);
    end
    if (tx_ready1 !== 1'b1) begin bad++; $display("FAIL mid_ready: got %b want 1", tx_ready1); end
  endtask

  task automatic test_loopback16();
    int fe0, ov0, n;
    loop1 = 1'b1;
    rx_ready1 = 1'b1;
    step();
    rx_q1.delete(); tx_exp1.delete();
    fe0 = fe_cnt1; ov0 = ov_cnt1;
    for (int i = 0; i < 200; i++) push_word1(16'($urandom_range(0, 65535)));
    tx_valid1 = 1'b0;
    n = 0;
    while (rx_q1.size() < 200 && n < 1000) begin step(); n++; end
    repeat (3) step();
    total += 2;
    if (rx_q1.size() != 200) begin bad++; $display("FAIL lb16_count: got %0d want 200", rx_q1.size()); end
    if (fe_cnt1 - fe0 !== 0 || ov_cnt1 - ov0 !== 0) begin
      bad++; $display("FAIL lb16_pulses: got fe=%0d ov=%0d want 0 0", fe_cnt1 - fe0, ov_cnt1 - ov0);
    end
    for (int i = 0; i < 200 && i < rx_q1.size(); i++) begin
      total++;
      if (rx_q1[i] !== tx_exp1[i]) begin
        bad++; $display("FAIL lb16_word%0d: got %h want %h", i, rx_q1[i], tx_exp1[i]);
      end
    end
  endtask

  task automatic test_loopback8();
    int fe0, ov0, n;
    rx_q2.delete(); tx_exp2.delete();
    fe0 = fe_cnt2; ov0 = ov_cnt2;
    for (int i = 0; i < 200; i++) push_word2(8'($urandom_range(0, 255)));
    tx_valid2 = 1'b0;
    n = 0;
    while (rx_q2.size() < 200 && n < 1000) begin step(); n++; end
    repeat (3) step();
    total += 3;
    if (rx_q2.size() != 200) begin bad++; $display("FAIL lb8_count: got %0d want 200", rx_q2.size()); end
    if (fe_cnt2 - fe0 !== 0 || ov_cnt2 - ov0 !== 0) begin
      bad++; $display("FAIL lb8_pulses: got fe=%0d ov=%0d want 0 0", fe_cnt2 - fe0, ov_cnt2 - ov0);
    end
    if (tx_level2 !== 4'd0) begin bad++; $display("FAIL lb8_level: got %0d want 0", tx_level2); end
    for (int i = 0; i < 200 && i < rx_q2.size(); i++) begin
      total++;
      if (rx_q2[i] !== tx_exp2[i]) begin
        bad++; $display("FAIL lb8_word%0d: got %h want %h", i, rx_q2[i], tx_exp2[i]);
      end
    end
  endtask

  initial begin
    si_drv    = 1'b1;
    loop1     = 1'b0;
    rx_ready1 = 1'b0;
    tx_valid1 = 1'b0;
    tx_data1  = '0;
    rx_ready2 = 1'b1;
    tx_valid2 = 1'b0;
    tx_data2  = '0;
    test_reset();
    test_rx_single();
    test_rx_errors();
    test_overrun();
    test_tx_burst();
    test_fifo_boundary();
    test_reset_mid_tx();
    test_loopback16();
    test_loopback8();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
